// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: two-entry (main + skid) buffer between the ALU and
// the MEM stage, plus EX-stage forwarding and load-use hazard outputs that are
// taken from the main slot.
// Optional feature: define EXMEM_PERF_CNT_EN to add ALU-stall and backpressure
// cycle counters (perf_alu_stall_o, perf_bp_stall_o).
module ex_mem_pipe #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                ex_valid_i,
  input  logic                alu_stall_i,
  output logic                ex_ready_o,
  input  logic [XLEN-1:0]     ex_pc_i,
  input  logic [XLEN-1:0]     ex_result_i,
  input  logic [XLEN-1:0]     ex_sdata_i,
  input  logic [REG_ADDR-1:0] ex_rd_i,
  input  logic                ex_rf_we_i,
  input  logic                ex_mem_re_i,
  input  logic                ex_mem_we_i,
  input  logic [1:0]          ex_mem_size_i,
  input  logic                ex_mem_uns_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [XLEN-1:0]     mem_pc_o,
  output logic [XLEN-1:0]     mem_result_o,
  output logic [XLEN-1:0]     mem_sdata_o,
  output logic [REG_ADDR-1:0] mem_rd_o,
  output logic                mem_rf_we_o,
  output logic                mem_re_o,
  output logic                mem_we_o,
  output logic [1:0]          mem_size_o,
  output logic                mem_uns_o,
`ifdef EXMEM_PERF_CNT_EN
  output logic [31:0]         perf_alu_stall_o,
  output logic [31:0]         perf_bp_stall_o,
`endif
  output logic                fwd_valid_o,
  output logic [REG_ADDR-1:0] fwd_rd_o,
  output logic [XLEN-1:0]     fwd_data_o,
  output logic                load_use_o
);

  // Payload layout: {pc, result, sdata, rd, rf_we, mem_re, mem_we, size, uns}
  localparam int PW = 3*XLEN + REG_ADDR + 6;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_pl_q, main_pl_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic [PW-1:0] ex_pl_s;
  logic          ex_fire_s;
  logic          mem_fire_s;

  assign ex_pl_s = {ex_pc_i, ex_result_i, ex_sdata_i, ex_rd_i, ex_rf_we_i,
                    ex_mem_re_i, ex_mem_we_i, ex_mem_size_i, ex_mem_uns_i};

  // The skid slot is only ever occupied while main is occupied, so "skid empty"
  // is exactly "room for one more op"; it comes straight from a flop.
  assign ex_ready_o  = ~skid_valid_q;
  assign mem_valid_o = main_valid_q;
  assign ex_fire_s   = ex_valid_i & ex_ready_o & ~alu_stall_i & ~flush_i;
  assign mem_fire_s  = main_valid_q & mem_ready_i;

  assign {mem_pc_o, mem_result_o, mem_sdata_o, mem_rd_o, mem_rf_we_o,
          mem_re_o, mem_we_o, mem_size_o, mem_uns_o} = main_pl_q;

  // Slot sequencing: flush kills both slots, otherwise main refills from skid
  // first (FIFO order) and the skid absorbs an op only when main is stuck.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pl_d    = main_pl_q;
    skid_pl_d    = skid_pl_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || mem_fire_s) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pl_d    = skid_pl_q;
      end else if (ex_fire_s) begin
        main_valid_d = 1'b1;
        main_pl_d    = ex_pl_s;
      end else begin
        main_valid_d = 1'b0;
      end
      skid_valid_d = 1'b0;
    end else if (ex_fire_s) begin
      skid_valid_d = 1'b1;
      skid_pl_d    = ex_pl_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Slot state registers; payload only changes when a slot is (re)loaded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pl_q    <= {PW{1'b0}};
      skid_pl_q    <= {PW{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pl_q    <= main_pl_d;
      skid_pl_q    <= skid_pl_d;
    end
  end

  // Hazard outputs from the main slot only; loads never forward (data not yet
  // available), they instead request a decode stall.
  always_comb begin
    fwd_rd_o   = mem_rd_o;
    fwd_data_o = mem_result_o;
    if (main_valid_q && (mem_rd_o != {REG_ADDR{1'b0}})) begin
      fwd_valid_o = mem_rf_we_o & ~mem_re_o;
      load_use_o  = mem_re_o;
    end else begin
      fwd_valid_o = 1'b0;
      load_use_o  = 1'b0;
    end
  end

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] perf_alu_q, perf_alu_d;
  logic [31:0] perf_bp_q, perf_bp_d;

  // Stall-event counters; free-running modulo 2^32, independent of flush.
  always_comb begin
    perf_alu_d = perf_alu_q;
    perf_bp_d  = perf_bp_q;
    if (ex_valid_i && alu_stall_i) begin
      perf_alu_d = perf_alu_q + 32'd1;
    end else begin
      perf_alu_d = perf_alu_q;
    end
    if (ex_valid_i && !ex_ready_o) begin
      perf_bp_d = perf_bp_q + 32'd1;
    end else begin
      perf_bp_d = perf_bp_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_alu_q <= 32'd0;
      perf_bp_q  <= 32'd0;
    end else begin
      perf_alu_q <= perf_alu_d;
      perf_bp_q  <= perf_bp_d;
    end
  end

  assign perf_alu_stall_o = perf_alu_q;
  assign perf_bp_stall_o  = perf_bp_q;
`endif

endmodule
